// File: rtl/proc_io_fifo.sv
// Processor I/O block: a FIFO per external input and output channel, with processor read/write ports and stall.
// Optional interrupt request is enabled by defining PROC_IO_ITR_EN.

module proc_io_fifo_chan #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign head    = mem[rd_ptr];
    // A full FIFO never accepts a push, even when it is popped in the same cycle.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end
endmodule

module proc_io_fifo #(
    parameter int                NUBITS = 16,
    parameter int                NUIOIN = 2,
    parameter int                NUIOOU = 2,
    parameter int                FDEPTH = 4,
    parameter logic [NUIOIN-1:0] ITRMSK = '1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_in,
    input  logic [$clog2(NUIOIN)-1:0]  addr_in,
    output logic [NUBITS-1:0]          io_in,
    input  logic                       out_en,
    input  logic [$clog2(NUIOOU)-1:0]  addr_out,
    input  logic [NUBITS-1:0]          io_out,
    output logic                       stall,
    output logic                       itr,
    input  logic [NUIOIN*NUBITS-1:0]   ext_in_data,
    input  logic [NUIOIN-1:0]          ext_in_valid,
    output logic [NUIOIN-1:0]          ext_in_ready,
    output logic [NUIOOU*NUBITS-1:0]   ext_out_data,
    output logic [NUIOOU-1:0]          ext_out_valid,
    input  logic [NUIOOU-1:0]          ext_out_ready
);
    localparam int AIW = $clog2(NUIOIN);
    localparam int AOW = $clog2(NUIOOU);

    logic [NUIOIN-1:0]        in_push;
    logic [NUIOIN-1:0]        in_pop;
    logic [NUIOIN-1:0]        in_empty;
    logic [NUIOIN-1:0]        in_full;
    logic [NUIOIN*NUBITS-1:0] in_head;
    logic [NUIOOU-1:0]        out_push;
    logic [NUIOOU-1:0]        out_pop;
    logic [NUIOOU-1:0]        out_empty;
    logic [NUIOOU-1:0]        out_full;
    logic [NUBITS-1:0]        rd_word;
    logic                     rd_stall;
    logic                     wr_stall;

    assign in_push       = ext_in_valid & ~in_full;
    assign ext_in_ready  = ~in_full;
    assign out_pop       = ext_out_ready & ~out_empty;
    assign ext_out_valid = ~out_empty;
    assign stall         = rst & (rd_stall | wr_stall);

    // Out-of-range channel addresses match no channel, so they neither pop/push nor stall.
    always_comb begin
        rd_word  = '0;
        rd_stall = 1'b0;
        in_pop   = '0;
        for (int k = 0; k < NUIOIN; k++) begin
            if (req_in && addr_in == AIW'(k)) begin
                if (in_empty[k]) begin
                    rd_stall = 1'b1;
                end else begin
                    in_pop[k] = 1'b1;
                    rd_word   = in_head[k*NUBITS +: NUBITS];
                end
            end
        end
    end

    always_comb begin
        wr_stall = 1'b0;
        out_push = '0;
        for (int j = 0; j < NUIOOU; j++) begin
            if (out_en && addr_out == AOW'(j)) begin
                if (out_full[j]) wr_stall = 1'b1;
                else             out_push[j] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         io_in <= '0;
        else if (|in_pop) io_in <= rd_word;
    end

`ifdef PROC_IO_ITR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) itr <= 1'b0;
        else      itr <= |(ITRMSK & ~in_empty);
    end
`else
    assign itr = 1'b0;
`endif

    for (genvar k = 0; k < NUIOIN; k++) begin : g_in
        proc_io_fifo_chan #(.WIDTH(NUBITS), .DEPTH(FDEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (in_push[k]),
            .pop   (in_pop[k]),
            .wdata (ext_in_data[k*NUBITS +: NUBITS]),
            .head  (in_head[k*NUBITS +: NUBITS]),
            .empty (in_empty[k]),
            .full  (in_full[k])
        );
    end

    for (genvar j = 0; j < NUIOOU; j++) begin : g_out
        proc_io_fifo_chan #(.WIDTH(NUBITS), .DEPTH(FDEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (out_push[j]),
            .pop   (out_pop[j]),
            .wdata (io_out),
            .head  (ext_out_data[j*NUBITS +: NUBITS]),
            .empty (out_empty[j]),
            .full  (out_full[j])
        );
    end
endmodule

// File: tb/tb_proc_io_fifo.sv
// Directed bench for proc_io_fifo: a vector table plus hand-written multi-cycle sequences.
// Interrupt expectations follow whether PROC_IO_ITR_EN is defined.

module tb_proc_io_fifo;
    typedef struct {
        logic        req;
        logic [0:0]  ra;
        logic        oe;
        logic [0:0]  wa;
        logic [15:0] wd;
        logic [1:0]  iv;
        logic [31:0] id;
        logic [1:0]  ordy;
        logic        e_stall;
        logic [15:0] e_io;
        logic [1:0]  e_irdy;
        logic [1:0]  e_oval;
        logic [31:0] e_odata;
    } vec_t;

`ifdef PROC_IO_ITR_EN
    localparam logic EXP_ITR = 1'b1;
`else
    localparam logic EXP_ITR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_in;
    logic [0:0]  addr_in;
    logic [15:0] io_in;
    logic        out_en;
    logic [0:0]  addr_out;
    logic [15:0] io_out;
    logic        stall;
    logic        itr;
    logic [31:0] ext_in_data;
    logic [1:0]  ext_in_valid;
    logic [1:0]  ext_in_ready;
    logic [31:0] ext_out_data;
    logic [1:0]  ext_out_valid;
    logic [1:0]  ext_out_ready;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] q[$];
    logic [15:0] exp_io;
    vec_t vecs [14];

    always #5 clk = ~clk;

    proc_io_fifo #(
        .NUBITS(16), .NUIOIN(2), .NUIOOU(2), .FDEPTH(4), .ITRMSK(2'b10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_in        (req_in),
        .addr_in       (addr_in),
        .io_in         (io_in),
        .out_en        (out_en),
        .addr_out      (addr_out),
        .io_out        (io_out),
        .stall         (stall),
        .itr           (itr),
        .ext_in_data   (ext_in_data),
        .ext_in_valid  (ext_in_valid),
        .ext_in_ready  (ext_in_ready),
        .ext_out_data  (ext_out_data),
        .ext_out_valid (ext_out_valid),
        .ext_out_ready (ext_out_ready)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        req_in = 1'b0; addr_in = 1'b0; out_en = 1'b0; addr_out = 1'b0; io_out = 16'h0;
        ext_in_valid = 2'b00; ext_in_data = 32'h0; ext_out_ready = 2'b00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_io = 16'h0;
        q.delete();
    endtask

    task automatic apply_stimulus(input vec_t v);
        req_in = v.req; addr_in = v.ra; out_en = v.oe; addr_out = v.wa; io_out = v.wd;
        ext_in_valid = v.iv; ext_in_data = v.id; ext_out_ready = v.ordy;
    endtask

    // One cycle on input channel 0 against a queue model of the FIFO; io_in reflects the previous pop.
    task automatic chan0_cycle(input logic pv, input logic [15:0] pd, input logic rd);
        logic was_full;
        @(negedge clk);
        ext_in_valid = {1'b0, pv}; ext_in_data = {16'h0, pd}; req_in = rd; addr_in = 1'b0;
        #2;
        was_full = (q.size() == 4);
        check_output("c_io_in", io_in, exp_io);
        check_output("c_ready0", ext_in_ready[0], !was_full);
        check_output("c_stall", stall, rd && q.size() == 0);
        if (rd && q.size() > 0) exp_io = q.pop_front();
        if (pv && !was_full) q.push_back(pd);
    endtask

    initial begin
        logic [15:0] wb [5];
        int          idx;
        logic        accepted;

        vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,16'h0000,2'b00,32'h0000_0000,2'b00, 1'b0,16'h0000,2'b11,2'b00,32'h0};
        vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,16'h0000,2'b10,32'h1234_0000,2'b00, 1'b0,16'h0000,2'b11,2'b00,32'h0};
        vecs[2]  = '{1'b1,1'b1,1'b0,1'b0,16'h0000,2'b00,32'h0000_0000,2'b00, 1'b0,16'h0000,2'b11,2'b00,32'h0};
        vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,16'h0000,2'b00,32'h0000_0000,2'b00, 1'b0,16'h1234,2'b11,2'b00,32'h0};
        vecs[4]  = '{1'b1,1'b1,1'b0,1'b0,16'h0000,2'b00,32'h0000_0000,2'b00, 1'b1,16'h1234,2'b11,2'b00,32'h0};
        vecs[5]  = '{1'b0,1'b0,1'b1,1'b1,16'hBEEF,2'b00,32'h0000_0000,2'b00, 1'b0,16'h1234,2'b11,2'b00,32'h0};
        vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,16'h0000,2'b00,32'h0000_0000,2'b00, 1'b0,16'h1234,2'b11,2'b10,32'hBEEF_0000};
        vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,16'h0000,2'b00,32'h0000_0000,2'b10, 1'b0,16'h1234,2'b11,2'b10,32'hBEEF_0000};
        vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,16'h0000,2'b00,32'h0000_0000,2'b00, 1'b0,16'h1234,2'b11,2'b00,32'h0};
        vecs[9]  = '{1'b1,1'b0,1'b1,1'b0,16'h5555,2'b00,32'h0000_0000,2'b00, 1'b1,16'h1234,2'b11,2'b00,32'h0};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b0,16'h0000,2'b00,32'h0000_0000,2'b00, 1'b0,16'h1234,2'b11,2'b01,32'h0000_5555};
        vecs[11] = '{1'b1,1'b0,1'b0,1'b0,16'h0000,2'b01,32'h0000_00AA,2'b00, 1'b1,16'h1234,2'b11,2'b01,32'h0000_5555};
        vecs[12] = '{1'b1,1'b0,1'b0,1'b0,16'h0000,2'b00,32'h0000_0000,2'b01, 1'b0,16'h1234,2'b11,2'b01,32'h0000_5555};
        vecs[13] = '{1'b0,1'b0,1'b0,1'b0,16'h0000,2'b00,32'h0000_0000,2'b00, 1'b0,16'h00AA,2'b11,2'b00,32'h0};

        // Reset state, with a read request held so stall must stay low during reset.
        clear_inputs();
        rst = 1'b0;
        req_in = 1'b1;
        #2;
        check_output("rst_io_in", io_in, 16'h0);
        check_output("rst_stall", stall, 1'b0);
        check_output("rst_itr", itr, 1'b0);
        check_output("rst_oval", ext_out_valid, 2'b00);
        do_reset();

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            apply_stimulus(vecs[i]);
            #2;
            check_output($sformatf("v%0d_stall", i), stall, vecs[i].e_stall);
            check_output($sformatf("v%0d_io_in", i), io_in, vecs[i].e_io);
            check_output($sformatf("v%0d_in_ready", i), ext_in_ready, vecs[i].e_irdy);
            check_output($sformatf("v%0d_out_valid", i), ext_out_valid, vecs[i].e_oval);
            for (int j = 0; j < 2; j++) begin
                if (vecs[i].e_oval[j])
                    check_output($sformatf("v%0d_out_data%0d", i, j), ext_out_data[j*16 +: 16],
                                 vecs[i].e_odata[j*16 +: 16]);
            end
        end

        // Read stalls on an empty channel until a word arrives.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req_in = 1'b1; addr_in = 1'b0;
            #2;
            check_output("a_stall_empty", stall, 1'b1);
            check_output("a_io_hold", io_in, 16'h0);
        end
        @(negedge clk);
        ext_in_valid = 2'b01; ext_in_data = 32'h0000_00AA;
        #2;
        check_output("a_stall_arrive", stall, 1'b1);
        @(negedge clk);
        ext_in_valid = 2'b00;
        #2;
        check_output("a_stall_drop", stall, 1'b0);
        check_output("a_io_before", io_in, 16'h0);
        @(negedge clk);
        req_in = 1'b0;
        #2;
        check_output("a_io_after", io_in, 16'h00AA);

        // Output channel 0 fills at 4, the 5th write stalls until the consumer drains.
        do_reset();
        wb = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            out_en = 1'b1; addr_out = 1'b0; io_out = wb[i]; ext_out_ready = 2'b00;
            #2;
            check_output($sformatf("b_stall_w%0d", i), stall, i == 4);
        end
        @(negedge clk);
        ext_out_ready = 2'b01;
        #2;
        check_output("b_stall_pop_full", stall, 1'b1);
        check_output("b_valid0", ext_out_valid[0], 1'b1);
        check_output("b_data_w0", ext_out_data[15:0], wb[0]);
        idx = 1;
        accepted = 1'b0;
        for (int c = 0; c < 20 && idx < 5; c++) begin
            @(negedge clk);
            if (accepted) out_en = 1'b0;
            #2;
            if (out_en && !stall) accepted = 1'b1;
            if (ext_out_valid[0]) begin
                check_output($sformatf("b_data_w%0d", idx), ext_out_data[15:0], wb[idx]);
                idx++;
            end
        end
        check_output("b_drain_count", idx, 5);
        check_output("b_fifth_accepted", accepted, 1'b1);
        @(negedge clk);
        ext_out_ready = 2'b00;
        #2;
        check_output("b_empty_after", ext_out_valid[0], 1'b0);

        // Input channel 0: fill, blocked push when full, then 10 words through the wrapping pointers.
        do_reset();
        for (int i = 0; i < 4; i++) chan0_cycle(1'b1, 16'hC000 + 16'(i), 1'b0);
        chan0_cycle(1'b1, 16'hDEAD, 1'b1);
        for (int i = 4; i < 10; i++) chan0_cycle(1'b1, 16'hC000 + 16'(i), 1'b1);
        for (int i = 0; i < 3; i++) chan0_cycle(1'b0, 16'h0, 1'b1);
        chan0_cycle(1'b0, 16'h0, 1'b0);
        check_output("c_last_word", exp_io, 16'hC009);

        // Interrupt with only channel 1 enabled.
        do_reset();
        @(negedge clk);
        ext_in_valid = 2'b01; ext_in_data = 32'h0000_0011;
        @(negedge clk);
        ext_in_valid = 2'b00;
        #2;
        check_output("d_itr_ch0_a", itr, 1'b0);
        @(negedge clk);
        #2;
        check_output("d_itr_ch0_b", itr, 1'b0);
        @(negedge clk);
        ext_in_valid = 2'b10; ext_in_data = 32'h0022_0000;
        @(negedge clk);
        ext_in_valid = 2'b00;
        #2;
        check_output("d_itr_landed", itr, 1'b0);
        @(negedge clk);
        #2;
        check_output("d_itr_rise", itr, EXP_ITR);
        @(negedge clk);
        req_in = 1'b1; addr_in = 1'b1;
        #2;
        check_output("d_read_stall", stall, 1'b0);
        @(negedge clk);
        req_in = 1'b0;
        #2;
        check_output("d_itr_hold", itr, EXP_ITR);
        check_output("d_io_in", io_in, 16'h0022);
        @(negedge clk);
        #2;
        check_output("d_itr_fall", itr, 1'b0);

        // Reset with three words buffered.
        do_reset();
        @(negedge clk);
        ext_in_valid = 2'b11; ext_in_data = 32'hB001_A001;
        out_en = 1'b1; addr_out = 1'b1; io_out = 16'hC001;
        @(negedge clk);
        ext_in_valid = 2'b01; ext_in_data = 32'h0000_A002;
        out_en = 1'b0; req_in = 1'b1; addr_in = 1'b1;
        @(negedge clk);
        clear_inputs();
        #2;
        check_output("e_io_pre", io_in, 16'hB001);
        check_output("e_oval_pre", ext_out_valid, 2'b10);
        req_in = 1'b1; addr_in = 1'b0; out_en = 1'b1; addr_out = 1'b1; io_out = 16'hC002;
        #1;
        rst = 1'b0;
        #1;
        check_output("e_rst_io_in", io_in, 16'h0);
        check_output("e_rst_itr", itr, 1'b0);
        check_output("e_rst_oval", ext_out_valid, 2'b00);
        check_output("e_rst_stall", stall, 1'b0);
        @(negedge clk);
        out_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #2;
        check_output("e_ready", ext_in_ready, 2'b11);
        check_output("e_stall_ch0", stall, 1'b1);
        check_output("e_oval_post", ext_out_valid, 2'b00);
        addr_in = 1'b1;
        #1;
        check_output("e_stall_ch1", stall, 1'b1);
        check_output("e_io_post", io_in, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
